// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Width convention for users: ADDR_W = clog2(DEPTH), PTR_W = ADDR_W + 1.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 8;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [clog2(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FWFT FIFO with occupancy, thresholds and sticky error flags.
// Define FIFO_SYNC_PARAM_STATS_EN to build the max_level high-water-mark register.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         data_out,
    output logic                      ready,
    output logic                      full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [clog2(DEPTH):0]     count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err,
    output logic [clog2(DEPTH):0]     max_level
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_CNT = PTR_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] ONE    = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic             rd_accept, wr_accept;
    logic             ovf_evt, udf_evt;

    // Wrap-bit pointers: MSB difference with equal low bits means every entry is occupied.
    assign count        = wr_ptr - rd_ptr;
    assign ready        = (wr_ptr != rd_ptr);
    assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                          (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign rd_accept = rd_en && ready;
    assign wr_accept = wr_en && (!full || rd_accept);
    assign ovf_evt   = wr_en && !wr_accept;
    assign udf_evt   = rd_en && !ready;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_accept) wr_ptr_nxt = wr_ptr + ONE;
        if (rd_accept) rd_ptr_nxt = rd_ptr + ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            overflow  <= (overflow  && !clr_err) || ovf_evt;
            underflow <= (underflow && !clr_err) || udf_evt;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (data_out)
    );

`ifdef FIFO_SYNC_PARAM_STATS_EN
    logic [PTR_W-1:0] count_nxt;
    assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

    // A clear restarts tracking from the post-edge occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_level <= '0;
        end else if (clr_err || (count_nxt > max_level)) begin
            max_level <= count_nxt;
        end
    end
`else
    assign max_level = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: queue-based model checked every cycle plus directed literals.
module tb_fifo_sync_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              rd_en = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              ready, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]        count, max_level;

    int checks = 0;
    int errors = 0;

    fifo_sync_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LVL),
        .AE_LEVEL (AE_LVL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .ready        (ready),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err),
        .max_level    (max_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents as a queue, flags from the acceptance rules.
    logic [DATA_W-1:0] q[$];
    bit m_ovf = 0, m_udf = 0;
    int m_max = 0;

    always @(negedge rst) begin
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_max = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            bit rd_ok, wr_ok, was_full;
            was_full = (q.size() == DEPTH);
            rd_ok    = rd_en && (q.size() > 0);
            wr_ok    = wr_en && (!was_full || rd_ok);
            m_ovf    = (m_ovf && !clr_err) || (wr_en && !wr_ok);
            m_udf    = (m_udf && !clr_err) || (rd_en && !rd_ok);
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(data_in);
`ifdef FIFO_SYNC_PARAM_STATS_EN
            if (clr_err || q.size() > m_max) m_max = q.size();
`endif
        end
    end

    always @(negedge clk) begin
        check("count",        32'(count),        32'(q.size()));
        check("ready",        32'(ready),        32'(q.size() != 0));
        check("full",         32'(full),         32'(q.size() == DEPTH));
        check("almost_full",  32'(almost_full),  32'(q.size() >= AF_LVL));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE_LVL));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        check("max_level",    32'(max_level),    32'(m_max));
        if (q.size() != 0) check("data_out", 32'(data_out), 32'(q[0]));
    end

    // One clock of stimulus; returns at posedge+1 with requests deasserted.
    task automatic step(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit c);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        #22 rst = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), 32'(i + 1 >= 6));
        end
        check("fill_full", 32'(full), 1);
        check("fill_ovf", 32'(overflow), 0);

        // Drain, data in order
        for (int unsigned i = 0; i < 8; i++) begin
            check("drain_data", 32'(data_out), 32'(8'h11 + i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_ready", 32'(ready), 0);

        // Overflow at full, then clear
        for (int unsigned i = 0; i < 8; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 8);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 0);

        // Simultaneous read+write at full
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("rw_full_ovf", 32'(overflow), 0);
        check("rw_full_count", 32'(count), 8);
        for (int unsigned i = 0; i < 7; i++) begin
            check("rw_full_data", 32'(data_out), 32'(8'h22 + i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("rw_full_last", 32'(data_out), 32'h55);
        step(1'b0, '0, 1'b1, 1'b0);

        // Underflow on empty, then read+write on empty
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_set", 32'(underflow), 1);
        check("udf_count", 32'(count), 0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        check("rw_empty_count", 32'(count), 1);
        check("rw_empty_data", 32'(data_out), 32'h33);
        check("rw_empty_udf", 32'(underflow), 1);
        step(1'b0, '0, 1'b1, 1'b1);

        // 20 write/read pairs, pointers wrap
        for (int unsigned i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h80 + 3 * i), 1'b0, 1'b0);
            check("pair_count1", 32'(count), 1);
            check("pair_data", 32'(data_out), 32'(8'(8'h80 + 3 * i)));
            step(1'b0, '0, 1'b1, 1'b0);
            check("pair_count0", 32'(count), 0);
        end
        check("pair_flags", 32'({overflow, underflow}), 0);

        // Asynchronous reset mid-operation
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 5; i++) step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 5);
        check("pre_rst_udf", 32'(underflow), 1);
`ifdef FIFO_SYNC_PARAM_STATS_EN
        check("pre_rst_max", 32'(max_level), 5);
`endif
        #2 rst = 1'b0;
        #1;
        check("async_count", 32'(count), 0);
        check("async_ready", 32'(ready), 0);
        check("async_udf", 32'(underflow), 0);
        check("async_max", 32'(max_level), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check("post_rst_data", 32'(data_out), 32'h77);
        check("post_rst_count", 32'(count), 1);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO. Successor to the team's fixed 8x8 FIFO.
- Adds configurable width and depth, full use of all DEPTH entries, an occupancy count, almost-full/almost-empty thresholds, and sticky overflow/underflow flags with explicit clear.
- Sits between byte/word producers and consumers on the same clock, e.g. UART/bus staging buffers.
- Read data is first-word-fall-through: the head word is always visible on data_out.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of storage entries; power of two, >=2.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request; pops the head word.
- data_out  out  DATA_W  head word (FWFT); don't-care when empty.
- ready  out  1  FIFO non-empty.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow (and max_level, see feature).
- max_level  out  $clog2(DEPTH)+1  high-water mark; tied 0 unless the feature is enabled.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, overflow=0, underflow=0, max_level=0.
  - Outputs then: count=0, ready=0, full=0, almost_empty=1, almost_full=0.
  - Storage contents are not reset.
- Reset asserted mid-operation discards all contents immediately. The first write after release lands in entry 0.
- Pointers are $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - Empty when the pointers are equal; full when the MSBs differ and the low bits are equal. All DEPTH entries are usable.
- Write accepted when wr_en && (!full || rd_accept): stores data_in at wr_ptr[ADDR_W-1:0], wr_ptr+1.
- Read accepted (rd_accept) when rd_en && ready: rd_ptr+1. data_out shows the next word in the following cycle.
- Write latency: a word written at edge N is visible on data_out after edge N if the FIFO was empty (zero bubble beyond one clock).
- Rejected write (wr_en && full && !rd_accept): data dropped, pointers unchanged, overflow<=1 at that edge.
- Rejected read (rd_en && !ready): pointers unchanged, underflow<=1.
- Simultaneous read+write:
  - When full: both accepted, count stays DEPTH, no overflow.
  - When empty: write accepted, read rejected (underflow set), count becomes 1.
  - Otherwise: both accepted, count unchanged.
- clr_err at an edge clears overflow/underflow. If a new rejection happens in the same cycle, the flag is set (set wins over clear).
- Pointer wrap is natural modulo arithmetic; no special casing.
- All flags except overflow/underflow/max_level are combinational from the pointers.

Optional Feature:
- Macro: FIFO_SYNC_PARAM_STATS_EN.
- Defined: max_level register updates each cycle to the maximum of itself and the post-edge count. It is cleared by reset or clr_err; if both clr_err and a higher count occur in the same cycle, it loads the new count.
- Not defined: no register is built; max_level is driven constant 0.

Decomposition:
- Package fifo_pkg:
  - clog2 constant function.
  - Default-parameter constants: FIFO_DATA_W_DEF=8, FIFO_DEPTH_DEF=8.
  - Pointer-width helper localparam convention: ADDR_W = clog2(DEPTH), PTR_W = ADDR_W+1.
- One sub-module, fifo_ram: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
- The top level holds the pointers, flags and the stats logic.

Test Plan:
- Reset, then write 0x11..0x18 (8 writes, DEPTH=8) -> full=1 and count=8 after the 8th edge, almost_full=1 from count 6, no overflow. Read all 8 -> data_out sequence 0x11..0x18, ready=0 at the end.
- At full, wr_en with 0xAA only -> overflow=1, count=8, 0xAA never read. clr_err pulse -> overflow=0.
- At full, wr_en=1 with 0x55 and rd_en=1 -> no overflow, count stays 8, 0x55 emerges last.
- Empty, rd_en only -> underflow=1, count=0. Empty, rd_en+wr_en 0x33 -> count=1, data_out=0x33, underflow=1.
- 20 single write/read pairs (pointer wrap twice) -> data matches in order, count toggles 0/1, no flags set.
- Fill to 5, assert rst low asynchronously mid-cycle -> count=0, ready=0, flags cleared immediately. With STATS_EN, max_level=5 before reset and 0 after.
